walk_request: RTL and testbench

WALK_REQUEST -- requirements
Module: walk_request

---
 rtl/walk_request.sv | 131 +++++++++++++
 tb/tb_walk_request.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/walk_request.sv
// Pedestrian walk-request front end: synchronizes and debounces a push-button,
// latches a request for the traffic controller and sequences service/lockout.
module walk_request #(
  parameter int DEBOUNCE    = 4,
  parameter int LOCKOUT     = 10,
  parameter int URGENT_WAIT = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       Walk_G,
  output logic       walk_req,
  output logic       urgent,
  output logic [7:0] served_cnt,
  output logic [1:0] state
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int LW = $clog2(LOCKOUT + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT - 1);
  localparam logic [7:0]    URG_TH    = 8'(URGENT_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVING = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic            sync1_r, btn_s;
  logic            btn_stable, btn_stable_q;
  logic [DW-1:0]   deb_cnt_r;
  logic [LW-1:0]   lock_cnt_r;
  logic [7:0]      wait_cnt_r;
  logic [7:0]      served_r;
  logic            press_s;

  // two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      btn_s   <= sync1_r;
    end
  end

  // debounce: btn_stable follows btn_s only after DEBOUNCE differing cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_r    <= '0;
      btn_stable   <= 1'b0;
      btn_stable_q <= 1'b0;
    end else begin
      btn_stable_q <= btn_stable;
      if (btn_s == btn_stable) begin
        deb_cnt_r <= '0;
      end else if (deb_cnt_r == DEB_LAST) begin
        deb_cnt_r  <= '0;
        btn_stable <= ~btn_stable;
      end else begin
        deb_cnt_r <= deb_cnt_r + {{(DW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign press_s = btn_stable & ~btn_stable_q;

  // next-state decode; Walk_G outranks a simultaneous press
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Walk_G)       state_nxt_s = ST_SERVING;
        else if (press_s) state_nxt_s = ST_PENDING;
        else              state_nxt_s = ST_IDLE;
      end
      ST_PENDING: begin
        if (Walk_G) state_nxt_s = ST_SERVING;
        else        state_nxt_s = ST_PENDING;
      end
      ST_SERVING: begin
        if (!Walk_G) state_nxt_s = ST_LOCKOUT;
        else         state_nxt_s = ST_SERVING;
      end
      ST_LOCKOUT: begin
        if (Walk_G)                        state_nxt_s = ST_SERVING;
        else if (lock_cnt_r == LOCK_LAST)  state_nxt_s = ST_IDLE;
        else                               state_nxt_s = ST_LOCKOUT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // served, wait and lockout counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served_r   <= 8'd0;
      wait_cnt_r <= 8'd0;
      lock_cnt_r <= '0;
    end else begin
      if (state_r == ST_PENDING && Walk_G) served_r <= served_r + 8'd1;
      else                                 served_r <= served_r;

      if (state_r != ST_PENDING && state_nxt_s == ST_PENDING) wait_cnt_r <= 8'd0;
      else if (state_r == ST_PENDING && wait_cnt_r != 8'd255) wait_cnt_r <= wait_cnt_r + 8'd1;
      else                                                    wait_cnt_r <= wait_cnt_r;

      if (state_r == ST_LOCKOUT && state_nxt_s == ST_LOCKOUT)
        lock_cnt_r <= lock_cnt_r + {{(LW-1){1'b0}}, 1'b1};
      else
        lock_cnt_r <= '0;
    end
  end

  // outputs are pure decodes of registered state
  assign state      = state_r;
  assign walk_req   = (state_r == ST_PENDING);
  assign urgent     = (state_r == ST_PENDING) && (wait_cnt_r >= URG_TH);
  assign served_cnt = served_r;

endmodule

// File: tb/tb_walk_request.sv
// Directed bench for walk_request: a per-cycle vector table for press/service/
// lockout plus hand-written bounce, urgency, simultaneous and reset sequences.
module tb_walk_request;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       walk_g;
  logic       walk_req;
  logic       urgent;
  logic [7:0] served_cnt;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  walk_request dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .Walk_G     (walk_g),
    .walk_req   (walk_req),
    .urgent     (urgent),
    .served_cnt (served_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic       g;
    logic [1:0] st;
    logic [7:0] srv;
  } vec_t;

  localparam int NROWS = 41;
  vec_t tbl [NROWS];

  task automatic set_rows(input int lo, input int hi, input logic b, input logic g,
                          input logic [1:0] st, input logic [7:0] srv);
    for (int i = lo; i <= hi; i++) begin
      tbl[i].btn = b;
      tbl[i].g   = g;
      tbl[i].st  = st;
      tbl[i].srv = srv;
    end
  endtask

  task automatic check(input string name, input logic [1:0] est, input logic eurg,
                       input logic [7:0] esrv);
    logic ewr;
    ewr = (est == 2'd1);
    n_vec++;
    if (state !== est || walk_req !== ewr || urgent !== eurg || served_cnt !== esrv) begin
      n_err++;
      $display("FAIL %s: got state=%0d walk_req=%0b urgent=%0b served=%0d, want state=%0d walk_req=%0b urgent=%0b served=%0d",
               name, state, walk_req, urgent, served_cnt, est, ewr, eurg, esrv);
    end
  endtask

  // drive inputs on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic b, input logic g);
    @(negedge clk);
    btn_raw = b;
    walk_g  = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // press held 10 cycles, pending, 8 cycles of Walk_G, lockout with a held press
    set_rows(0,  5,  1'b1, 1'b0, 2'd0, 8'd0);
    set_rows(6,  9,  1'b1, 1'b0, 2'd1, 8'd0);
    set_rows(10, 11, 1'b0, 1'b0, 2'd1, 8'd0);
    set_rows(12, 19, 1'b0, 1'b1, 2'd2, 8'd1);
    set_rows(20, 20, 1'b0, 1'b0, 2'd3, 8'd1);
    set_rows(21, 29, 1'b1, 1'b0, 2'd3, 8'd1);
    set_rows(30, 34, 1'b1, 1'b0, 2'd0, 8'd1);
    set_rows(35, 40, 1'b0, 1'b0, 2'd0, 8'd1);

    rst = 1'b1; btn_raw = 1'b0; walk_g = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 2'd0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NROWS; i++) begin
      step(tbl[i].btn, tbl[i].g);
      check($sformatf("table[%0d]", i), tbl[i].st, 1'b0, tbl[i].srv);
    end

    // bounce: two-cycle pulses never reach DEBOUNCE
    for (int i = 0; i < 16; i++) begin
      step((i < 8) && ((i % 4) < 2), 1'b0);
      check($sformatf("bounce[%0d]", i), 2'd0, 1'b0, 8'd1);
    end

    // urgency: pending entered after edge 6, urgent from 40 pending cycles on
    for (int i = 0; i < 66; i++) begin
      step(i < 8, 1'b0);
      check($sformatf("urgent[%0d]", i), (i >= 6) ? 2'd1 : 2'd0, i >= 46, 8'd1);
    end
    step(1'b0, 1'b1);
    check("urgent_serve", 2'd2, 1'b0, 8'd2);
    step(1'b0, 1'b0);
    check("urgent_lock_entry", 2'd3, 1'b0, 8'd2);
    for (int j = 1; j <= 10; j++) begin
      step(1'b0, 1'b0);
      check($sformatf("lockout[%0d]", j), (j == 10) ? 2'd0 : 2'd3, 1'b0, 8'd2);
    end

    // press event and Walk_G on the same edge from IDLE
    for (int i = 0; i < 10; i++) begin
      step(i < 8, i >= 6);
      check($sformatf("simul[%0d]", i), (i >= 6) ? 2'd2 : 2'd0, 1'b0, 8'd2);
    end
    step(1'b0, 1'b0);
    check("simul_lock_entry", 2'd3, 1'b0, 8'd2);
    for (int j = 1; j <= 10; j++) begin
      step(1'b0, 1'b0);
      check($sformatf("simul_lock[%0d]", j), (j == 10) ? 2'd0 : 2'd3, 1'b0, 8'd2);
    end
    repeat (3) begin
      step(1'b0, 1'b0);
      check("pre_reset_idle", 2'd0, 1'b0, 8'd2);
    end

    // asynchronous reset while a request is pending
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      check($sformatf("rst_press[%0d]", i), (i >= 6) ? 2'd1 : 2'd0, 1'b0, 8'd2);
    end
    #1;
    rst = 1'b1;
    btn_raw = 1'b0;
    #1;
    check("async_reset", 2'd0, 1'b0, 8'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("post_reset[%0d]", i), 2'd0, 1'b0, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
